// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: serialises 1/2/4-byte loads/stores onto an 8-bit RAM/IO bus, little-endian.
// Latency: done_o pulses len enabled edges after accept; en low freezes everything. Optional MEM_IO_GUARD_EN stalls IO stores while io_buffer_full.
// Backpressure: one request at a time, accepted only in IDLE; requester holds off until done_o.
`ifndef DATA_MEM_CTRL_OPS
`define DATA_MEM_CTRL_OPS
`define OP_W 4
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd8
`define SH  4'd9
`define SW  4'd10
`endif

module data_mem_ctrl #(
    parameter int          ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_en_i,
    input  logic              req_rwen_i,
    input  logic [`OP_W-1:0]  req_op_i,
    input  logic [2:0]        req_len_i,
    input  logic [ADDR_W-1:0] req_adr_i,
    input  logic [31:0]       req_dat_i,
    input  logic              flush_i,
    output logic              done_o,
    output logic [31:0]       dat_o,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, len_q, len_req;
    logic [`OP_W-1:0]  op_q;
    logic [ADDR_W-1:0] adr_q, adr_nxt;
    logic [31:0]       dat_q;
    logic [7:0]        byt0, byt1, byt2;
    logic [7:0]        st_byte;
    logic [31:0]       ld_raw, ld_ext;
    logic              wr_q, stall, last, accept;

    assign accept  = (state == IDLE) && req_en_i && !flush_i;
    assign last    = (cnt == len_q);
    assign adr_nxt = adr_q + ADDR_W'(cnt);

    // Anything other than 1 or 2 bytes is handled as a full word.
    always_comb begin
        case (req_len_i)
            3'd1:    len_req = 3'd1;
            3'd2:    len_req = 3'd2;
            default: len_req = 3'd4;
        endcase
    end

`ifdef MEM_IO_GUARD_EN
    assign stall = (state == WR) && wr_q && (mem_a >= ADDR_W'(IO_BASE)) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io = ^{io_buffer_full, IO_BASE};
    assign stall     = 1'b0;
`endif

    always_comb begin
        case (cnt[1:0])
            2'd1:    st_byte = dat_q[15:8];
            2'd2:    st_byte = dat_q[23:16];
            2'd3:    st_byte = dat_q[31:24];
            default: st_byte = dat_q[7:0];
        endcase
    end

    // The final byte is taken straight from the bus so no extra cycle is spent.
    always_comb begin
        case (len_q)
            3'd1:    ld_raw = {24'h0, mem_din};
            3'd2:    ld_raw = {16'h0, mem_din, byt0};
            default: ld_raw = {mem_din, byt2, byt1, byt0};
        endcase
        case (op_q)
            `LB:     ld_ext = {{24{ld_raw[7]}}, ld_raw[7:0]};
            `LH:     ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            `LBU:    ld_ext = {24'h0, ld_raw[7:0]};
            `LHU:    ld_ext = {16'h0, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = req_rwen_i ? WR : RD;
            RD:   if (flush_i || last) state_nxt = IDLE;
            WR:   if (!stall && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= 3'd0;
            len_q    <= 3'd0;
            op_q     <= '0;
            adr_q    <= '0;
            dat_q    <= 32'h0;
            byt0     <= 8'h0;
            byt1     <= 8'h0;
            byt2     <= 8'h0;
            wr_q     <= 1'b0;
            done_o   <= 1'b0;
            dat_o    <= 32'h0;
            mem_a    <= '0;
            mem_dout <= 8'h0;
        end else if (en) begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= req_op_i;
                        len_q <= len_req;
                        adr_q <= req_adr_i;
                        dat_q <= req_dat_i;
                        mem_a <= req_adr_i;
                        cnt   <= 3'd1;
                        if (req_rwen_i) begin
                            mem_dout <= req_dat_i[7:0];
                            wr_q     <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (flush_i) begin
                        mem_a <= '0;
                        cnt   <= 3'd0;
                    end else if (last) begin
                        done_o <= 1'b1;
                        dat_o  <= ld_ext;
                        mem_a  <= '0;
                        cnt    <= 3'd0;
                    end else begin
                        case (cnt)
                            3'd1:    byt0 <= mem_din;
                            3'd2:    byt1 <= mem_din;
                            default: byt2 <= mem_din;
                        endcase
                        mem_a <= adr_nxt;
                        cnt   <= cnt + 3'd1;
                    end
                end
                WR: begin
                    if (!stall) begin
                        if (last) begin
                            wr_q   <= 1'b0;
                            mem_a  <= '0;
                            done_o <= 1'b1;
                            dat_o  <= 32'h0;
                            cnt    <= 3'd0;
                        end else begin
                            mem_a    <= adr_nxt;
                            mem_dout <= st_byte;
                            cnt      <= cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Gating with en keeps a frozen byte from being written more than once.
    always_comb begin
        mem_wr = wr_q & en & ~stall;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: combinational RAM model plus a write log, immediate-assertion checks.
`ifndef DATA_MEM_CTRL_OPS
`define DATA_MEM_CTRL_OPS
`define OP_W 4
`define LB  4'd0
`define LH  4'd1
`define LW  4'd2
`define LBU 4'd4
`define LHU 4'd5
`define SB  4'd8
`define SH  4'd9
`define SW  4'd10
`endif

module tb_data_mem_ctrl;

    logic             clk = 1'b0;
    logic             rst, en, req_en_i, req_rwen_i, flush_i, io_buffer_full;
    logic [`OP_W-1:0] req_op_i;
    logic [2:0]       req_len_i;
    logic [31:0]      req_adr_i, req_dat_i;
    logic             done_o, mem_wr;
    logic [31:0]      dat_o, mem_a;
    logic [7:0]       mem_din, mem_dout;

    logic [7:0]  ram [0:4095];
    logic [31:0] wa [$];
    logic [7:0]  wd [$];
    int          n_assert = 0;
    int          n_fail   = 0;

    data_mem_ctrl dut (
        .clk(clk), .rst(rst), .en(en),
        .req_en_i(req_en_i), .req_rwen_i(req_rwen_i), .req_op_i(req_op_i),
        .req_len_i(req_len_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
        .flush_i(flush_i), .done_o(done_o), .dat_o(dat_o),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    assign mem_din = ram[mem_a[11:0]];

    always @(posedge clk) begin
        if (mem_wr) begin
            wa.push_back(mem_a);
            wd.push_back(mem_dout);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request for one cycle; returns just after the accept edge.
    task automatic req(input logic rw, input logic [3:0] op, input logic [2:0] len,
                       input logic [31:0] adr, input logic [31:0] dat);
        req_en_i   = 1'b1;
        req_rwen_i = rw;
        req_op_i   = op;
        req_len_i  = len;
        req_adr_i  = adr;
        req_dat_i  = dat;
        tick();
        req_en_i   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req_en_i = 1'b0; req_rwen_i = 1'b0; flush_i = 1'b0;
        io_buffer_full = 1'b0; req_op_i = '0; req_len_i = 3'd0; req_adr_i = 32'h0; req_dat_i = 32'h0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h84;
        ram[12'h200] = 8'hF0; ram[12'h210] = 8'h34; ram[12'h211] = 8'h92;
        ram[12'hFFF] = 8'h55; ram[12'h000] = 8'h80;

        repeat (2) tick();
        chk("rst_done", {31'h0, done_o}, 32'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_dout", {24'h0, mem_dout}, 32'h0);
        chk("rst_wr", {31'h0, mem_wr}, 32'h0);
        rst = 1'b0;
        tick();

        // Word load
        req(1'b0, `LW, 3'd4, 32'h100, 32'h0);
        chk("lw_a0", mem_a, 32'h100);
        chk("lw_done0", {31'h0, done_o}, 32'h0);
        tick(); chk("lw_a1", mem_a, 32'h101);
        tick(); chk("lw_a2", mem_a, 32'h102);
        tick(); chk("lw_a3", mem_a, 32'h103);
        chk("lw_done3", {31'h0, done_o}, 32'h0);
        tick();
        chk("lw_done", {31'h0, done_o}, 32'h1);
        chk("lw_dat", dat_o, 32'h8433_2211);
        chk("lw_a_idle", mem_a, 32'h0);
        tick(); chk("lw_pulse", {31'h0, done_o}, 32'h0);

        // Byte / half loads with extension
        req(1'b0, `LB, 3'd1, 32'h200, 32'h0);
        tick();
        chk("lb_done", {31'h0, done_o}, 32'h1);
        chk("lb_dat", dat_o, 32'hFFFF_FFF0);
        tick(); chk("lb_pulse", {31'h0, done_o}, 32'h0);
        req(1'b0, `LBU, 3'd1, 32'h200, 32'h0);
        tick(); chk("lbu_dat", dat_o, 32'h0000_00F0);
        req(1'b0, `LH, 3'd2, 32'h210, 32'h0);
        chk("lh_a0", mem_a, 32'h210);
        tick(); chk("lh_a1", mem_a, 32'h211);
        tick();
        chk("lh_done", {31'h0, done_o}, 32'h1);
        chk("lh_dat", dat_o, 32'hFFFF_9234);

        // Address wrap at the top of the space
        req(1'b0, `LHU, 3'd2, 32'hFFFF_FFFF, 32'h0);
        chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        tick(); chk("wrap_a1", mem_a, 32'h0);
        tick(); chk("wrap_dat", dat_o, 32'h0000_8055);

        // Length 3 handled as a word
        req(1'b0, `LW, 3'd3, 32'h100, 32'h0);
        repeat (3) tick();
        chk("len3_early", {31'h0, done_o}, 32'h0);
        tick();
        chk("len3_done", {31'h0, done_o}, 32'h1);
        chk("len3_dat", dat_o, 32'h8433_2211);

        // Half store
        wa.delete(); wd.delete();
        req(1'b1, `SH, 3'd2, 32'h300, 32'hDEAD_BEEF);
        chk("sh_wr0", {31'h0, mem_wr}, 32'h1);
        chk("sh_a0", mem_a, 32'h300);
        chk("sh_d0", {24'h0, mem_dout}, 32'hEF);
        tick();
        chk("sh_wr1", {31'h0, mem_wr}, 32'h1);
        chk("sh_a1", mem_a, 32'h301);
        chk("sh_d1", {24'h0, mem_dout}, 32'hBE);
        chk("sh_done1", {31'h0, done_o}, 32'h0);
        tick();
        chk("sh_done", {31'h0, done_o}, 32'h1);
        chk("sh_dat", dat_o, 32'h0);
        chk("sh_wr_end", {31'h0, mem_wr}, 32'h0);
        chk("sh_nwr", wa.size(), 32'd2);
        chk("sh_log_a1", wa[1], 32'h301);
        chk("sh_log_d0", {24'h0, wd[0]}, 32'hEF);

        // Flush during a load
        req(1'b0, `LW, 3'd4, 32'h100, 32'h0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_ld_a", mem_a, 32'h0);
        chk("fl_ld_done", {31'h0, done_o}, 32'h0);
        tick();
        chk("fl_ld_done2", {31'h0, done_o}, 32'h0);
        chk("fl_ld_idle", mem_a, 32'h0);

        // Flush coincident with a request in IDLE
        wa.delete(); wd.delete();
        req_en_i = 1'b1; req_rwen_i = 1'b1; req_op_i = `SB; req_len_i = 3'd1;
        req_adr_i = 32'h600; req_dat_i = 32'h77; flush_i = 1'b1;
        tick();
        req_en_i = 1'b0; flush_i = 1'b0;
        chk("fl_idle_wr", {31'h0, mem_wr}, 32'h0);
        chk("fl_idle_a", mem_a, 32'h0);
        tick();
        chk("fl_idle_done", {31'h0, done_o}, 32'h0);

        // Flush during a store is ignored
        req(1'b1, `SW, 3'd4, 32'h400, 32'h1122_3344);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_st_a1", mem_a, 32'h401);
        repeat (2) tick();
        chk("fl_st_early", {31'h0, done_o}, 32'h0);
        tick();
        chk("fl_st_done", {31'h0, done_o}, 32'h1);
        chk("fl_st_nwr", wa.size(), 32'd4);
        chk("fl_st_a3", wa[3], 32'h403);
        for (int i = 0; i < 4; i++)
            chk("fl_st_byte", {24'h0, wd[i]}, 32'h1122_3344 >> (8 * i) & 32'hFF);

        // Freeze mid-store with en low
        wa.delete(); wd.delete();
        req(1'b1, `SW, 3'd4, 32'h500, 32'hA1B2_C3D4);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_wr", {31'h0, mem_wr}, 32'h0);
        end
        chk("frz_a", mem_a, 32'h501);
        en = 1'b1;
        repeat (2) tick();
        chk("frz_early", {31'h0, done_o}, 32'h0);
        tick();
        chk("frz_done", {31'h0, done_o}, 32'h1);
        chk("frz_nwr", wa.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("frz_log_a", wa[i], 32'h500 + i);
            chk("frz_log_d", {24'h0, wd[i]}, 32'hA1B2_C3D4 >> (8 * i) & 32'hFF);
        end

        // Reset mid-load abandons it
        req(1'b0, `LW, 3'd4, 32'h100, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_a", mem_a, 32'h0);
        rst = 1'b0;
        repeat (4) tick();
        chk("mid_rst_done", {31'h0, done_o}, 32'h0);

        // IO-mapped store with a full output buffer
        wa.delete(); wd.delete();
        io_buffer_full = 1'b1;
        req(1'b1, `SB, 3'd1, 32'h0003_0000, 32'h41);
`ifdef MEM_IO_GUARD_EN
        chk("io_wr_stall", {31'h0, mem_wr}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("io_wr_held", {31'h0, mem_wr}, 32'h0);
            chk("io_done_held", {31'h0, done_o}, 32'h0);
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io_wr_rel", {31'h0, mem_wr}, 32'h1);
        chk("io_dout", {24'h0, mem_dout}, 32'h41);
        tick();
        chk("io_done", {31'h0, done_o}, 32'h1);
`else
        chk("io_wr", {31'h0, mem_wr}, 32'h1);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_dout", {24'h0, mem_dout}, 32'h41);
        tick();
        chk("io_done", {31'h0, done_o}, 32'h1);
        io_buffer_full = 1'b0;
`endif
        chk("io_nwr", wa.size(), 32'd1);
        chk("io_log_d", {24'h0, wd[0]}, 32'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Data-side memory controller directly downstream of the load-store buffer. Accepts one load or store request at a time (1/2/4 bytes) and serialises it onto the 8-bit synchronous RAM/IO bus, one byte per cycle, little-endian. Loads are assembled and sign- or zero-extended per op. Completion is returned as a single-cycle done pulse with data.

Parameters:
ADDR_W, 32, byte address width
IO_BASE, 32'h0003_0000, first IO-mapped address (used only under the optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable (rdy); low freezes all state
req_en_i  in  1  request valid, sampled only in IDLE
req_rwen_i  in  1  0 = load, 1 = store
req_op_i  in  `OP_W  opcode (`LB/`LH/`LW/`LBU/`LHU/`SB/`SH/`SW)
req_len_i  in  3  byte count 1/2/4
req_adr_i  in  ADDR_W  start byte address
req_dat_i  in  32  store data, bytes [7:0] first
flush_i  in  1  misprediction flush
done_o  out  1  one-cycle completion pulse
dat_o  out  32  extended load data; 0 for stores
mem_din  in  8  RAM read byte, valid the cycle after its address is driven
mem_dout  out  8  RAM write byte
mem_a  out  ADDR_W  RAM byte address
mem_wr  out  1  write strobe (1 = write)
io_buffer_full  in  1  IO output buffer full

Behaviour:
- Reset (async): state IDLE, cnt 0, done_o 0, dat_o 0, mem_a 0, mem_dout 0, internal wr register 0. Reset mid-transfer abandons it; no done.
- en low: no state, counter or output-register update; mem_wr = wr_reg & en, so no byte is written while frozen. The held byte is issued exactly once after en returns.
- States: IDLE, RD, WR.
- IDLE, req_en_i=1, flush_i=0: latch op, len, adr, dat. Set mem_a <= adr, cnt <= 1.
  - Load: go to RD.
  - Store: go to WR, with mem_dout <= dat[7:0] and wr <= 1.
- Lengths other than 1, 2 or 4 are treated as 4.
- RD, each enabled edge: byte[cnt-1] <= mem_din.
  - cnt == len: done_o <= 1, dat_o <= assembled value, mem_a <= 0, go to IDLE.
  - Otherwise: mem_a <= adr+cnt, cnt++.
- Load extension: `LB/`LH sign-extend from bit 7/15; `LBU/`LHU/`LW zero-extend/pass. The final byte comes from mem_din directly (no extra cycle).
- WR, each enabled edge:
  - cnt == len: wr <= 0, mem_a <= 0, done_o <= 1, dat_o <= 0, go to IDLE.
  - Otherwise: mem_a <= adr+cnt, mem_dout <= dat byte cnt, cnt++.
- Latency: done_o rises exactly len enabled edges after the accept edge. The next request is accepted no earlier than the edge after done_o.
- done_o is a single-cycle pulse, cleared on every enabled edge where not set.
- Address increment is modulo 2^ADDR_W (wrap at 32'hFFFF_FFFF to 0).
- Flush (flush_i=1 with en):
  - In RD: abort immediately, go to IDLE, mem_a <= 0, no done_o. A load completing on the same edge is suppressed.
  - In WR: ignored. The committed store finishes and done_o still pulses.
  - In IDLE: any coincident req_en_i is ignored.
- req_en_i outside IDLE is ignored; the requester holds off until done_o.

Optional Feature:
MEM_IO_GUARD_EN
- Defined: in WR, if the current byte address >= IO_BASE and io_buffer_full=1, mem_wr is gated low and cnt/state/mem_a/mem_dout hold. The byte is written once after io_buffer_full falls. done_o is delayed by the stall cycles.
- Undefined: io_buffer_full is ignored; the upstream buffer alone guards IO stores.

Test Plan:
- Word load at 0x100; RAM bytes 0x11,0x22,0x33,0x84 -> mem_a 0x100..0x103 on consecutive cycles; done_o 4 cycles after accept; dat_o 0x84332211.
- `LB at 0x200 with byte 0xF0 -> done_o after 1 cycle, dat_o 0xFFFFFFF0; repeat with `LBU -> 0x000000F0; `LH with bytes 0x34,0x92 -> 0xFFFF9234.
- `SH of 0xDEADBEEF at 0x300 -> mem_wr high 2 cycles, (0x300,0xEF) then (0x301,0xBE); done_o 2 cycles after accept; mem_wr 0 afterwards.
- `LW accepted, flush_i at cnt 2 -> back to IDLE next edge, no done_o; `SW with flush_i during cnt 1 -> all 4 bytes written, done_o pulses.
- en low for 3 cycles mid-`SW at cnt 2 -> mem_wr 0 while frozen; each of the 4 addresses written exactly once; done_o delayed by 3 cycles.
- (MEM_IO_GUARD_EN) `SB 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> no write until release, then one write of 0x41, done_o next edge; with the macro undefined -> write and done_o 1 cycle after accept.
